// File: rtl/alu_op_sequencer_if.sv
// CPU-side request/result bundle of the ALU op sequencer.
// The CPU control unit is the master; the sequencer is the slave.
interface alu_op_sequencer_if;
  logic        iValid;
  logic        oReady;
  logic [3:0]  iCtrl;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iFlush;
  logic [31:0] oHi;
  logic [31:0] oLo;
  logic        oZero;
  logic        oNeg;
  logic        oDone;
  logic        oBusy;

  modport master (
    output iValid, iCtrl, iA, iB, iFlush,
    input  oReady, oHi, oLo, oZero, oNeg, oDone, oBusy
  );

  modport slave (
    input  iValid, iCtrl, iA, iB, iFlush,
    output oReady, oHi, oLo, oZero, oNeg, oDone, oBusy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/retire controller in front of a combinational ALU: holds operands stable
// for a per-opcode number of cycles, then captures HI/LO and the Z/N flags.
module alu_op_sequencer #(
  parameter int         BASE_CYCLES  = 1,
  parameter int         MUL_CYCLES   = 4,
  parameter int         DIV_CYCLES   = 8,
  parameter logic [3:0] CTRL_ALU_MUL = 4'd8,
  parameter logic [3:0] CTRL_ALU_DIV = 4'd9
) (
  input  logic               iClk,
  input  logic               iRst,
  alu_op_sequencer_if.slave  bus,
  output logic [31:0]        oAluA,
  output logic [31:0]        oAluB,
  output logic [3:0]         oAluCtrl,
  input  logic [31:0]        iAluHi,
  input  logic [31:0]        iAluLo,
  input  logic               iAluZero,
  input  logic               iAluNeg
);

  localparam int MAX_BM = (BASE_CYCLES > MUL_CYCLES) ? BASE_CYCLES : MUL_CYCLES;
  localparam int MAX_L  = (MAX_BM > DIV_CYCLES) ? MAX_BM : DIV_CYCLES;
  localparam int CW     = $clog2(MAX_L) + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   lat_m1;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            zero_q, zero_d, neg_q, neg_d;
  logic            done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic            long_op;

  always_comb begin
    if (bus.iCtrl == CTRL_ALU_MUL) begin
      lat_m1 = CW'(MUL_CYCLES - 1);
    end else if (bus.iCtrl == CTRL_ALU_DIV) begin
      lat_m1 = CW'(DIV_CYCLES - 1);
    end else begin
      lat_m1 = CW'(BASE_CYCLES - 1);
    end
  end

  // HI is only written by ops that actually produce a high word.
  assign long_op = (ctrl_q == CTRL_ALU_MUL) || (ctrl_q == CTRL_ALU_DIV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    if (bus.iFlush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_EXEC: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            lo_d    = iAluLo;
            zero_d  = iAluZero;
            neg_d   = iAluNeg;
            if (long_op) begin
              hi_d = iAluHi;
            end
            state_d = S_DONE;
          end
        end
        default: begin
          if (bus.iValid) begin
            a_d     = bus.iA;
            b_d     = bus.iB;
            ctrl_d  = bus.iCtrl;
            cnt_d   = lat_m1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end

    done_d  = (state_d == S_DONE);
    busy_d  = (state_d == S_EXEC);
    ready_d = (state_d != S_EXEC);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign oAluA      = a_q;
  assign oAluB      = b_q;
  assign oAluCtrl   = ctrl_q;
  assign bus.oHi    = hi_q;
  assign bus.oLo    = lo_q;
  assign bus.oZero  = zero_q;
  assign bus.oNeg   = neg_q;
  assign bus.oDone  = done_q;
  assign bus.oBusy  = busy_q;
  assign bus.oReady = ready_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vectors, hand-built abort sequences and
// a randomized run against a transaction-level model, with a model ALU behind the DUT.
module tb_alu_op_sequencer;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        n;
  } alu_res_t;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        n;
    int          lat;
  } vec_t;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] alu_a, alu_b, alu_hi, alu_lo;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_neg;
  alu_res_t    alu_env;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .BASE_CYCLES (1),
    .MUL_CYCLES  (4),
    .DIV_CYCLES  (8),
    .CTRL_ALU_MUL(OP_MUL),
    .CTRL_ALU_DIV(OP_DIV)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .bus     (bus),
    .oAluA   (alu_a),
    .oAluB   (alu_b),
    .oAluCtrl(alu_ctrl),
    .iAluHi  (alu_hi),
    .iAluLo  (alu_lo),
    .iAluZero(alu_zero),
    .iAluNeg (alu_neg)
  );

  always #5 iClk = ~iClk;

  function automatic alu_res_t alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_res_t r;
    logic [63:0] p;
    int q, m;
    r = '0;
    case (c)
      OP_ADD: r.lo = a + b;
      OP_SUB: r.lo = a - b;
      4'd2:   r.lo = a & b;
      4'd3:   r.lo = a | b;
      4'd4:   r.lo = a ^ b;
      OP_MUL: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          r.hi = '1;
          r.lo = a;
        end else if (a == 32'h8000_0000 && b == '1) begin
          r.hi = a;
          r.lo = 32'd0;
        end else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r.hi = q;
          r.lo = (m < 0) ? -m : m;
        end
      end
      default: r = '0;
    endcase
    if (c == OP_MUL || c == OP_DIV) begin
      r.z = ({r.hi, r.lo} == 64'd0);
      r.n = r.hi[31];
    end else begin
      r.z = (r.lo == 32'd0);
      r.n = r.lo[31];
    end
    return r;
  endfunction

  function automatic int op_lat(input logic [3:0] c);
    return (c == OP_MUL) ? 4 : (c == OP_DIV) ? 8 : 1;
  endfunction

  always_comb alu_env = alu_model(alu_ctrl, alu_a, alu_b);
  assign alu_hi   = alu_env.hi;
  assign alu_lo   = alu_env.lo;
  assign alu_zero = alu_env.z;
  assign alu_neg  = alu_env.n;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!bus.oReady && t < 40) begin
      step();
      t++;
    end
    if (!bus.oReady) check({name, " ready timeout"}, 160'(bus.oReady), 160'(1));
  endtask

  vec_t vecs[4];
  logic [31:0] cur_hi, cur_lo;

  // Transaction-level model state for the randomized run.
  logic        m_have, m_done, m_z, m_n;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_ctrl;
  int          m_done_at, edge_idx;

  initial begin
    int lat, busy_cnt;
    alu_res_t r;

    vecs[0] = '{"T1 add", OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0, 1};
    vecs[1] = '{"T2 mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1'b0, 4};
    vecs[2] = '{"T3 sub", OP_SUB, 32'd5, 32'd5, 32'd1, 32'd0, 1'b1, 1'b0, 1};
    vecs[3] = '{"T4 div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1, 8};

    bus.iValid = 1'b0;
    bus.iCtrl  = 4'd0;
    bus.iA     = 32'd0;
    bus.iB     = 32'd0;
    bus.iFlush = 1'b0;
    step();
    step();
    check("reset state", {bus.oReady, bus.oBusy, bus.oDone, bus.oHi, bus.oLo, bus.oZero, bus.oNeg, alu_a, alu_b, alu_ctrl},
          {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0});
    iRst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      wait_ready(vecs[i].name);
      bus.iValid = 1'b1;
      bus.iCtrl  = vecs[i].ctrl;
      bus.iA     = vecs[i].a;
      bus.iB     = vecs[i].b;
      step();
      bus.iValid = 1'b0;
      busy_cnt = int'(bus.oBusy);
      lat = 0;
      while (!bus.oDone && lat < 32) begin
        bus.iA = $urandom;
        bus.iB = $urandom;
        bus.iCtrl = 4'($urandom);
        step();
        lat++;
        if (bus.oBusy) busy_cnt++;
      end
      check({vecs[i].name, " latency"}, 160'(lat), 160'(vecs[i].lat));
      check({vecs[i].name, " busy cycles"}, 160'(busy_cnt), 160'(vecs[i].lat));
      check({vecs[i].name, " result"}, {bus.oHi, bus.oLo, bus.oZero, bus.oNeg},
            {vecs[i].hi, vecs[i].lo, vecs[i].z, vecs[i].n});
      step();
      check({vecs[i].name, " done single pulse"}, {bus.oDone, bus.oReady}, {1'b0, 1'b1});
    end

    // T5: request held through DONE is taken in that same cycle.
    bus.iValid = 1'b1;
    bus.iCtrl  = OP_ADD;
    bus.iA     = 32'd1;
    bus.iB     = 32'd2;
    step();
    bus.iA = 32'd3;
    bus.iB = 32'd4;
    step();
    check("T5 first done", {bus.oDone, bus.oReady, bus.oLo}, {1'b1, 1'b1, 32'd3});
    step();
    bus.iValid = 1'b0;
    check("T5 second accepted", {bus.oDone, bus.oBusy, bus.oReady, alu_a, alu_b}, {1'b0, 1'b1, 1'b0, 32'd3, 32'd4});
    step();
    check("T5 second done", {bus.oDone, bus.oHi, bus.oLo}, {1'b1, 32'hFFFF_FFFD, 32'd7});
    step();
    cur_hi = 32'hFFFF_FFFD;
    cur_lo = 32'd7;

    // T6: flush in the third EXEC cycle of a DIV.
    bus.iValid = 1'b1;
    bus.iCtrl  = OP_DIV;
    bus.iA     = 32'd100;
    bus.iB     = 32'd7;
    step();
    bus.iValid = 1'b0;
    step();
    step();
    check("T6 div in exec", {bus.oBusy, bus.oReady}, {1'b1, 1'b0});
    bus.iFlush = 1'b1;
    step();
    bus.iFlush = 1'b0;
    check("T6 flush to idle", {bus.oBusy, bus.oReady, bus.oDone, bus.oHi, bus.oLo},
          {1'b0, 1'b1, 1'b0, cur_hi, cur_lo});
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.oDone) lat++;
    end
    check("T6 no done after flush", 160'(lat), 160'(0));

    // Flush wins over a request presented in the same cycle.
    bus.iFlush = 1'b1;
    bus.iValid = 1'b1;
    bus.iCtrl  = OP_ADD;
    bus.iA     = 32'd9;
    bus.iB     = 32'd9;
    step();
    bus.iFlush = 1'b0;
    bus.iValid = 1'b0;
    check("flush drops request", {bus.oBusy, bus.oReady, alu_a}, {1'b0, 1'b1, 32'd100});
    step();
    check("flush drops request done", {bus.oDone, bus.oLo}, {1'b0, cur_lo});

    // T6: asynchronous reset in the middle of a MUL.
    bus.iValid = 1'b1;
    bus.iCtrl  = OP_MUL;
    bus.iA     = 32'd3;
    bus.iB     = 32'd3;
    step();
    bus.iValid = 1'b0;
    step();
    #2;
    iRst = 1'b1;
    #1;
    check("T6 async reset", {bus.oReady, bus.oBusy, bus.oDone, bus.oHi, bus.oLo, bus.oZero, bus.oNeg, alu_a, alu_b, alu_ctrl},
          {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0});
    step();
    iRst = 1'b0;
    step();
    check("T6 no done after reset", {bus.oDone, bus.oReady}, {1'b0, 1'b1});

    // Randomized run checked cycle by cycle against the transaction model.
    m_have = 1'b0; m_done = 1'b0; m_z = 1'b0; m_n = 1'b0;
    m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_ctrl = '0;
    m_done_at = 0;
    edge_idx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.iValid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0: bus.iCtrl = OP_MUL;
        1: bus.iCtrl = OP_DIV;
        2: bus.iCtrl = 4'($urandom);
        default: bus.iCtrl = 4'($urandom_range(0, 4));
      endcase
      bus.iA = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      bus.iB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      bus.iFlush = ($urandom_range(0, 24) == 0);

      if (bus.iFlush) begin
        m_have = 1'b0;
        m_done = 1'b0;
      end else if (m_have) begin
        m_done = 1'b0;
        if (edge_idx == m_done_at) begin
          r = alu_model(m_ctrl, m_a, m_b);
          m_lo = r.lo;
          m_z  = r.z;
          m_n  = r.n;
          if (m_ctrl == OP_MUL || m_ctrl == OP_DIV) m_hi = r.hi;
          m_done = 1'b1;
          m_have = 1'b0;
        end
      end else begin
        m_done = 1'b0;
        if (bus.iValid) begin
          m_a = bus.iA;
          m_b = bus.iB;
          m_ctrl = bus.iCtrl;
          m_have = 1'b1;
          m_done_at = edge_idx + op_lat(bus.iCtrl);
        end
      end

      step();
      edge_idx++;
      n_cmp++;
      if ({bus.oDone, bus.oBusy, bus.oReady, bus.oHi, bus.oLo, bus.oZero, bus.oNeg, alu_a, alu_b, alu_ctrl} !==
          {m_done, m_have, !m_have, m_hi, m_lo, m_z, m_n, m_a, m_b, m_ctrl}) begin
        n_bad++;
        $display("FAIL rand cyc %0d: done/busy/ready=%b%b%b hi=%h lo=%h z=%b n=%b a=%h b=%h c=%h expected %b%b%b hi=%h lo=%h z=%b n=%b a=%h b=%h c=%h",
                 cyc, bus.oDone, bus.oBusy, bus.oReady, bus.oHi, bus.oLo, bus.oZero, bus.oNeg, alu_a, alu_b, alu_ctrl,
                 m_done, m_have, !m_have, m_hi, m_lo, m_z, m_n, m_a, m_b, m_ctrl);
      end else begin
        $display("ok   rand cyc %0d: v=%b f=%b done=%b busy=%b lo=%h", cyc, bus.iValid, bus.iFlush, bus.oDone, bus.oBusy, bus.oLo);
      end
    end
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
